// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline payload types and default field widths
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_RW_W   = 5;

   typedef struct packed {
      logic                   syscall;
      logic                   we;
      logic [PIPE_RW_W-1:0]   rw;
      logic [PIPE_DATA_W-1:0] a;
      logic [PIPE_DATA_W-1:0] w;
   } pipe_payload_t;

   function automatic int payload_w(input int data_w, input int rw_w);
      return 2 + rw_w + 2 * data_w;
   endfunction

endpackage

// File: rtl/wb_stage_entry.sv
// rtl/wb_stage_entry.sv - one payload register with valid bit, load and clear
// An entry loaded with d_valid=0 becomes empty and holds an all-zero payload.
module wb_stage_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic         d_valid,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= d_valid;
         q     <= d_valid ? d : '0;
      end
   end

endmodule

// File: rtl/wb_stage_buf.sv
// rtl/wb_stage_buf.sv - elastic 2-entry (main + skid) pipeline stage buffer
// Optional stall counter enabled by defining WB_STAGE_STALL_CNT_EN.
module wb_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int RW_W   = PIPE_RW_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_syscall,
   input  logic              in_we,
   input  logic [RW_W-1:0]   in_rw,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_w,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_syscall,
   output logic              out_we,
   output logic [RW_W-1:0]   out_rw,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_w,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = payload_w(DATA_W, RW_W);

   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic [PW-1:0] main_d;
   logic          main_valid;
   logic          skid_valid;
   logic          accept;
   logic          drain;
   logic          main_load;
   logic          main_d_valid;
   logic          skid_load;
   logic          skid_clear;

   assign in_pl = {in_syscall, in_we, in_rw, in_a, in_w};

   // Ready depends only on registered skid state, never on out_ready.
   assign in_ready = !skid_valid && !rst;
   assign accept   = in_valid && in_ready;
   assign drain    = main_valid && out_ready;

   always_comb begin
      main_load    = 1'b0;
      main_d       = in_pl;
      main_d_valid = 1'b0;
      skid_load    = 1'b0;
      skid_clear   = flush;
      if (!flush) begin
         if (!main_valid || drain) begin
            main_load = 1'b1;
            if (skid_valid) begin
               main_d       = skid_q;
               main_d_valid = 1'b1;
               skid_clear   = 1'b1;
            end else begin
               main_d_valid = accept;
            end
         end else if (accept) begin
            skid_load = 1'b1;
         end
      end
   end

   wb_stage_entry #(.W(PW)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load),
      .clear   (flush),
      .d_valid (main_d_valid),
      .d       (main_d),
      .valid   (main_valid),
      .q       (main_q)
   );

   wb_stage_entry #(.W(PW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clear),
      .d_valid (1'b1),
      .d       (in_pl),
      .valid   (skid_valid),
      .q       (skid_q)
   );

   assign out_valid = main_valid;
   assign {out_syscall, out_we, out_rw, out_a, out_w} = main_q;

`ifdef WB_STAGE_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating; flush deliberately leaves the count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (main_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
